// File: rtl/phtime_mlane.sv
// phtime_mlane: multi-lane phase-time generator.
// Produces NLANE phase words per clock, lane k = freq*(NLANE*n + k) + phoff
// (mod 2^FW), using a bounded TCW-bit cycle counter times freq plus a wrap
// base, so the phase stays continuous indefinitely. Fixed 4-cycle latency
// from start to the first valid word.
// Optional macro PHTIME_MLANE_ERRCHK_EN adds a per-lane incremental reference
// accumulator and a sticky err flag; without it err is tied 0.
module phtime_mlane #(
  parameter int FW    = 27,
  parameter int NLANE = 4,
  parameter int TCW   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FW-1:0]         freq,
  input  logic [FW-1:0]         phoff,
  output logic [NLANE*FW-1:0]   phase,
  output logic                  valid,
  output logic                  busy,
  output logic                  err
);

  localparam int LNL = $clog2(NLANE);
  localparam int IW  = TCW + LNL;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [TCW-1:0]  r_n;
  logic [FW-1:0]   r_freq;
  logic [FW-1:0]   r_base0;
  logic            w_v0;
  logic [FW-1:0]   w_wrapInc;
  logic [FW-1:0]   w_prod [NLANE];

  logic            r_v1;
  logic [FW-1:0]   r_base1;
  logic [FW-1:0]   r_prod [NLANE];

  logic            r_v2;
  logic [FW-1:0]   r_sum  [NLANE];

  logic            r_valid;
  logic [FW-1:0]   r_phase [NLANE];

  assign w_v0 = (r_state == RUN);

  // One full counter period advances the phase by freq*NLANE*2^TCW; the shift
  // in an FW-wide context drops everything above the phase modulus.
  assign w_wrapInc = r_freq << IW;

  // Control FSM, cycle counter and wrap base (base starts at phoff so later
  // stages only need a single addition).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_freq  <= '0;
      r_base0 <= '0;
    end else if (start) begin
      r_state <= RUN;
      r_n     <= '0;
      r_freq  <= freq;
      r_base0 <= phoff;
    end else if (r_state == RUN) begin
      if (stop) begin
        r_state <= IDLE;
      end else begin
        r_n <= r_n + TCW'(1);
        if (&r_n) begin
          r_base0 <= r_base0 + w_wrapInc;
        end
      end
    end
  end

  // Per-lane product freq*(NLANE*n + k), truncated to the low FW bits.
  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      w_prod[k] = r_freq * FW'((IW'(r_n) << LNL) | IW'(k));
    end
  end

  // Stage 1: register the products together with the base they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_base1 <= '0;
      for (int k = 0; k < NLANE; k++) r_prod[k] <= '0;
    end else begin
      r_v1    <= w_v0;
      r_base1 <= r_base0;
      for (int k = 0; k < NLANE; k++) r_prod[k] <= w_prod[k];
    end
  end

  // Stage 2: add the wrap base (which already includes phoff).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2 <= 1'b0;
      for (int k = 0; k < NLANE; k++) r_sum[k] <= '0;
    end else begin
      r_v2 <= r_v1;
      for (int k = 0; k < NLANE; k++) r_sum[k] <= r_prod[k] + r_base1;
    end
  end

`ifdef PHTIME_MLANE_ERRCHK_EN
  logic [FW-1:0] w_injMask;
  assign w_injMask = '0;
`endif

  // Output stage: phase only updates on valid words, otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      for (int k = 0; k < NLANE; k++) r_phase[k] <= '0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) begin
        for (int k = 0; k < NLANE; k++) r_phase[k] <= r_sum[k];
`ifdef PHTIME_MLANE_ERRCHK_EN
        r_phase[0] <= r_sum[0] ^ w_injMask;
`endif
      end
    end
  end

  // Pack lanes onto the flat output bus.
  always_comb begin
    phase = '0;
    for (int k = 0; k < NLANE; k++) phase[k*FW +: FW] = r_phase[k];
  end

  assign valid = r_valid;
  assign busy  = w_v0 | r_v1 | r_v2 | r_valid;

`ifdef PHTIME_MLANE_ERRCHK_EN
  logic            r_f0, r_f1, r_f2;
  logic [FW-1:0]   r_phoff;
  logic [FW-1:0]   r_freq1, r_freq2, r_phoff1, r_phoff2;
  logic [FW-1:0]   r_ref [NLANE];
  logic            r_errSticky;
  logic            w_mis;

  // Latch phoff and mark the first issued word of each new sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f0    <= 1'b0;
      r_phoff <= '0;
    end else begin
      r_f0 <= start;
      if (start) r_phoff <= phoff;
    end
  end

  // Carry the sequence parameters alongside the data pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f1 <= 1'b0; r_f2 <= 1'b0;
      r_freq1 <= '0; r_freq2 <= '0;
      r_phoff1 <= '0; r_phoff2 <= '0;
    end else begin
      r_f1 <= r_f0 & w_v0; r_f2 <= r_f1;
      r_freq1 <= r_freq; r_freq2 <= r_freq1;
      r_phoff1 <= r_phoff; r_phoff2 <= r_phoff1;
    end
  end

  // Incremental reference, aligned with the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NLANE; k++) r_ref[k] <= '0;
    end else if (r_v2) begin
      for (int k = 0; k < NLANE; k++) begin
        if (r_f2) r_ref[k] <= r_freq2 * FW'(k) + r_phoff2;
        else      r_ref[k] <= r_ref[k] + FW'(r_freq2 * FW'(NLANE));
      end
    end
  end

  // Any lane disagreeing with its reference on a valid cycle.
  always_comb begin
    w_mis = 1'b0;
    if (r_valid) begin
      for (int k = 0; k < NLANE; k++) begin
        if (r_phase[k] != r_ref[k]) w_mis = 1'b1;
      end
    end
  end

  // Sticky error, cleared by reset or a new start.
  always_ff @(posedge clk) begin
    if (reset)      r_errSticky <= 1'b0;
    else if (start) r_errSticky <= 1'b0;
    else            r_errSticky <= r_errSticky | w_mis;
  end

  assign err = r_errSticky | w_mis;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phtime_mlane.sv
// Directed self-checking bench for phtime_mlane (FW=27, NLANE=4, TCW=4).
module tb_phtime_mlane;

   localparam int FW    = 27;
   localparam int NLANE = 4;
   localparam int TCW   = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                stop;
   logic [FW-1:0]       freq;
   logic [FW-1:0]       phoff;
   logic [NLANE*FW-1:0] phase;
   logic                valid;
   logic                busy;
   logic                err;

   int nTests = 0;
   int nFail  = 0;
   logic [FW-1:0] prevLane0;

   phtime_mlane #(.FW(FW), .NLANE(NLANE), .TCW(TCW)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .freq(freq), .phoff(phoff), .phase(phase),
      .valid(valid), .busy(busy), .err(err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Safety net so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic [FW-1:0] f, input logic [FW-1:0] o);
      start = s;
      stop  = p;
      freq  = f;
      phoff = o;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   function automatic logic [FW-1:0] lane(input int k);
      return phase[k*FW +: FW];
   endfunction

   function automatic logic [FW-1:0] model(input logic [FW-1:0] f, input logic [FW-1:0] o, input int t);
      logic [63:0] p;
      p = 64'(f) * 64'(t) + 64'(o);
      return p[FW-1:0];
   endfunction

   // Main directed sequence.
   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; freq = '0; phoff = '0;
      repeat (3) tick();
      checkOutput("rst_phase", 64'(phase), 64'h0);
      checkOutput("rst_valid", 64'(valid), 64'h0);
      checkOutput("rst_busy",  64'(busy),  64'h0);
      checkOutput("rst_err",   64'(err),   64'h0);
      reset = 1'b0;
      tick();

      // Basic sequence, start at cycle C
      applyStimulus(1'b1, 1'b0, 27'h100, 27'h10);
      checkOutput("basic_busy_c1",  64'(busy),  64'h1);
      checkOutput("basic_valid_c1", 64'(valid), 64'h0);
      tick();
      checkOutput("basic_valid_c2", 64'(valid), 64'h0);
      tick();
      checkOutput("basic_valid_c3", 64'(valid), 64'h0);
      tick();
      checkOutput("basic_valid_c4", 64'(valid), 64'h1);
      checkOutput("basic_l0_n0", 64'(lane(0)), 64'h010);
      checkOutput("basic_l1_n0", 64'(lane(1)), 64'h110);
      checkOutput("basic_l2_n0", 64'(lane(2)), 64'h210);
      checkOutput("basic_l3_n0", 64'(lane(3)), 64'h310);
      tick();
      checkOutput("basic_l0_n1", 64'(lane(0)), 64'h410);
      checkOutput("basic_l1_n1", 64'(lane(1)), 64'h510);
      checkOutput("basic_l2_n1", 64'(lane(2)), 64'h610);
      checkOutput("basic_l3_n1", 64'(lane(3)), 64'h710);
      for (int i = 2; i <= 6; i++) begin
         tick();
         checkOutput("basic_l0_run", 64'(lane(0)), 64'(27'h400 * i + 27'h10));
      end

      // Restart at R = C+10 with new freq/phoff
      applyStimulus(1'b1, 1'b0, 27'h40, 27'h20);
      for (int i = 0; i < 3; i++) begin
         checkOutput("rs_old_valid", 64'(valid), 64'h1);
         checkOutput("rs_old_l0", 64'(lane(0)), 64'(27'h1C10 + 27'h400 * i));
         tick();
      end
      checkOutput("rs_new_valid", 64'(valid), 64'h1);
      checkOutput("rs_new_l0", 64'(lane(0)), 64'h20);
      checkOutput("rs_new_l3", 64'(lane(3)), 64'hE0);
      for (int m = 1; m <= 6; m++) begin
         tick();
         checkOutput("rs_run_l0", 64'(lane(0)), 64'(27'h100 * m + 27'h20));
      end

      // Stop at S = C+20: last word at S+3, idle from S+4
      applyStimulus(1'b0, 1'b1, 27'h0, 27'h0);
      checkOutput("stop_l0_s1",   64'(lane(0)), 64'h720);
      checkOutput("stop_busy_s1", 64'(busy),    64'h1);
      tick();
      checkOutput("stop_l0_s2",   64'(lane(0)), 64'h820);
      tick();
      checkOutput("stop_valid_s3", 64'(valid),   64'h1);
      checkOutput("stop_l0_s3",    64'(lane(0)), 64'h920);
      tick();
      checkOutput("stop_valid_s4", 64'(valid),   64'h0);
      checkOutput("stop_busy_s4",  64'(busy),    64'h0);
      checkOutput("stop_hold_l0",  64'(lane(0)), 64'h920);

      // Stop while idle is ignored
      applyStimulus(1'b0, 1'b1, 27'h0, 27'h0);
      checkOutput("idle_stop_busy",  64'(busy),  64'h0);
      checkOutput("idle_stop_valid", 64'(valid), 64'h0);

      // Modulo wrap of the product
      applyStimulus(1'b1, 1'b0, 27'h7FFFFFF, 27'h1);
      repeat (3) tick();
      checkOutput("mod_l0", 64'(lane(0)), 64'h0000001);
      checkOutput("mod_l1", 64'(lane(1)), 64'h0000000);
      checkOutput("mod_l2", 64'(lane(2)), 64'h7FFFFFF);
      checkOutput("mod_l3", 64'(lane(3)), 64'h7FFFFFE);
      tick();
      checkOutput("mod_l0_n1", 64'(lane(0)), 64'h7FFFFFD);

      // Start and stop together while running: restart wins; then counter wrap
      applyStimulus(1'b1, 1'b1, 27'h3, 27'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("ss_gap_valid", 64'(valid), 64'h1);
         tick();
      end
      prevLane0 = '0;
      for (int n = 0; n < 40; n++) begin
         checkOutput("wrap_valid", 64'(valid), 64'h1);
         checkOutput("wrap_l0", 64'(lane(0)), 64'(model(27'h3, 27'h0, 4 * n)));
         checkOutput("wrap_l3", 64'(lane(3)), 64'(model(27'h3, 27'h0, 4 * n + 3)));
         if (n > 0) checkOutput("wrap_step", 64'(lane(0) - prevLane0), 64'hC);
         prevLane0 = lane(0);
         tick();
      end
      checkOutput("wrap_err", 64'(err), 64'h0);

      // Reset mid-run aborts immediately
      applyStimulus(1'b1, 1'b0, 27'h100, 27'h10);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      checkOutput("mrst_valid", 64'(valid), 64'h0);
      checkOutput("mrst_phase", 64'(phase), 64'h0);
      checkOutput("mrst_busy",  64'(busy),  64'h0);
      checkOutput("mrst_err",   64'(err),   64'h0);
      reset = 1'b0;
      tick();
      applyStimulus(1'b1, 1'b0, 27'h100, 27'h10);
      repeat (3) tick();
      checkOutput("post_rst_valid", 64'(valid), 64'h1);
      for (int k = 0; k < NLANE; k++) begin
         checkOutput("post_rst_lane", 64'(lane(k)), 64'(27'h100 * k + 27'h10));
      end

`ifdef PHTIME_MLANE_ERRCHK_EN
      // Single-bit flip on lane 0 through the injection hook
      force dut.w_injMask = 27'h1;
      tick();
      release dut.w_injMask;
      checkOutput("err_set",     64'(err),     64'h1);
      checkOutput("err_flip_l0", 64'(lane(0)), 64'h411);
      tick();
      checkOutput("err_held",    64'(err),     64'h1);
      checkOutput("err_l0_ok",   64'(lane(0)), 64'h810);
      applyStimulus(1'b1, 1'b0, 27'h100, 27'h10);
      checkOutput("err_clr", 64'(err), 64'h0);
`else
      repeat (4) tick();
      checkOutput("err_tied", 64'(err), 64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/phtime_mlane.md
Name: phtime_mlane

Overview:
- Parametrised successor of the single-lane phase-time generator.
- Produces NLANE phase words per clock for a multi-sample-per-clock DAC/ADC datapath: phase(t) = freq*t + phoff mod 2^FW, with t = NLANE*n + k for lane k.
- Uses a DSP-friendly bounded counter (TCW bits) multiplied by freq, plus a wrap-correction base, so phase stays continuous indefinitely.
- Adds start/stop control, phase offset, restart on the fly and a fixed pipeline latency.

Parameters:
- FW, 27, phase/frequency word width (bits); all phase arithmetic is mod 2^FW.
- NLANE, 4, samples (lanes) produced per clock; power of two, 1..16.
- TCW, 16, internal cycle-counter width; must satisfy TCW+log2(NLANE) <= 18 (27x18 DSP).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: latch freq/phoff, restart t at 0, enter RUN.
- stop  in  1  one-cycle pulse: end generation.
- freq  in  FW  phase increment per sample; sampled only on start.
- phoff  in  FW  phase offset; sampled only on start.
- phase  out  NLANE*FW  lane k at bits [k*FW +: FW].
- valid  out  1  phase word is valid this cycle.
- busy  out  1  RUN state or pipeline not yet drained.
- err  out  1  sticky mismatch flag (see Optional Feature); constant 0 otherwise.

Behaviour:
- Reset: phase=0, valid=0, busy=0, err=0; state IDLE; latched freq/phoff=0; counter and wrap base=0. Reset mid-RUN aborts immediately with no drain.
- States:
  - IDLE: waiting.
  - RUN: counter n increments each cycle from 0.
  - Transitions: IDLE->RUN on start; RUN->IDLE on stop; RUN->RUN on start (restart).
  - Start and stop in the same cycle: start wins.
  - Stop in IDLE: ignored.
- Latency: exactly 4 clk cycles, independent of parameters.
  - If start is asserted at cycle C, valid=1 from C+4, and lane k = (freq*k + phoff) mod 2^FW.
  - At cycle C+4+n: lane k = (freq*(NLANE*n + k) + phoff) mod 2^FW.
- Stop at cycle S (S > C): the last issued set is n = S-C-1, output at S+3; valid=0 from S+4.
- busy=1 from C+1 through the last valid cycle.
- Restart (start at R while running):
  - Outputs up to R+3 continue the old sequence.
  - The new sequence (n=0, new freq/phoff) appears at R+4.
  - valid stays 1 with no gap.
- Counter wrap:
  - When n reaches 2^TCW - 1, it wraps to 0 next cycle.
  - The wrap base is updated: base += freq*NLANE*2^TCW (mod 2^FW), applied in step with the pipeline so the output is continuous.
  - Across the wrap, the lane 0 step equals freq*NLANE mod 2^FW exactly.
- Arithmetic:
  - Product freq*(NLANE*n+k) is truncated to its low FW bits; all additions wrap mod 2^FW.
  - No saturation.
  - freq=0 gives a constant phoff on all lanes.
- When valid=0, phase holds its last value (held at 0 after reset).
- Pipeline registers for valid/phase are not cleared by stop; they drain naturally.

Optional Feature:
- Macro: PHTIME_MLANE_ERRCHK_EN.
- Defined:
  - A parallel incremental reference accumulator runs per lane: ref_k starts at freq*k + phoff and adds freq*NLANE each cycle, aligned to the same 4-cycle latency.
  - On any valid cycle where any lane differs from ref_k, err sets.
  - err is sticky until reset or the next start.
- Not defined: no reference logic is synthesised; err is tied 0.

Test Plan:
- Basic: FW=27, NLANE=4; reset; start at C with freq=0x100, phoff=0x10 -> valid rises at C+4; lanes = 0x010, 0x110, 0x210, 0x310; next cycle 0x410..0x710; busy=1 from C+1.
- Wrap: TCW=4, freq=0x3, phoff=0, run 40 cycles -> phase continuous across n=15->0, lane 0 step always 0xC, no discontinuity; err=0 with the macro defined.
- Modulo: freq=0x7FFFFFF, phoff=0x1 -> lane k = (1-k) mod 2^27 at n=0, e.g. lane 1 = 0x0, lane 2 = 0x7FFFFFF.
- Restart/stop: start with freq=0x100 at C, start with freq=0x40 at C+10 -> old sequence through C+13, lane 0 = phoff' at C+14, valid continuous; stop at C+20 -> valid=0 from C+24, busy=0 from C+24; start and stop together -> restart taken.
- Reset mid-RUN: assert reset at C+6 -> next cycle valid=0, phase=0, busy=0, err=0; a subsequent start produces the correct sequence from n=0.
- Error check (macro defined): force a single-bit flip on one lane's phase pipeline via a bench hook -> err=1 the same cycle, held until start; without the macro err stays 0.
